// File: rtl/role_trace_arb.sv
// Packet-level round-robin arbiter merging NUM_SRC trace streams onto one registered output.
// state | meaning
// IDLE  | no owner; when trace_en=1, grant the first valid source at or after rr_ptr
// BUSY  | grant_id owns the output until its tlast beat is accepted
module role_trace_arb #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 512,
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int KW = DATA_WIDTH / 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          trace_en,
    input  logic [NUM_SRC-1:0]            s_axis_trace_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_trace_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_trace_tdata,
    input  logic [NUM_SRC*KW-1:0]         s_axis_trace_tkeep,
    input  logic [NUM_SRC-1:0]            s_axis_trace_tlast,
    output logic                          m_axis_trace_tvalid,
    input  logic                          m_axis_trace_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_trace_tdata,
    output logic [KW-1:0]                 m_axis_trace_tkeep,
    output logic                          m_axis_trace_tlast,
    output logic                          grant_valid,
    output logic [SW-1:0]                 grant_id,
    output logic [31:0]                   pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]         grant_id_q, grant_id_d;

    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [KW-1:0]         m_keep_q;
    logic                  m_last_q;
    logic [31:0]           pkt_cnt_q;

    logic                  win_found;
    logic [SW-1:0]         win_id;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KW-1:0]         sel_keep;
    logic                  sel_last;
    logic                  out_free;
    logic                  beat_acc;
    logic                  out_hs;

    // Round-robin scan: first valid index at or after rr_ptr, wrapping at NUM_SRC.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!win_found && s_axis_trace_tvalid[idx]) begin
                win_found = 1'b1;
                win_id    = SW'(idx);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id_q == SW'(i)) begin
                sel_valid = s_axis_trace_tvalid[i];
                sel_data  = s_axis_trace_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_trace_tkeep[i*KW +: KW];
                sel_last  = s_axis_trace_tlast[i];
            end
        end
    end

    // Ready depends only on state and output occupancy; m_tready is the sole combinational input.
    assign out_free = !m_valid_q || m_axis_trace_tready;
    assign beat_acc = (state_q == BUSY) && sel_valid && out_free;
    assign out_hs   = m_valid_q && m_axis_trace_tready;

    always_comb begin
        s_axis_trace_tready = '0;
        if (state_q == BUSY) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_id_q == SW'(i)) begin
                    s_axis_trace_tready[i] = out_free;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (trace_en && win_found) begin
                    state_d    = BUSY;
                    grant_id_d = win_id;
                end
            end
            BUSY: begin
                if (beat_acc && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == SW'(NUM_SRC - 1)) ? '0 : grant_id_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    // Output register: a new load wins over a drain in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
        end else if (beat_acc) begin
            m_valid_q <= 1'b1;
            m_data_q  <= sel_data;
            m_keep_q  <= sel_keep;
            m_last_q  <= sel_last;
        end else if (m_axis_trace_tready) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt_q <= '0;
        end else if (out_hs && m_last_q && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign m_axis_trace_tvalid = m_valid_q;
    assign m_axis_trace_tdata  = m_data_q;
    assign m_axis_trace_tkeep  = m_keep_q;
    assign m_axis_trace_tlast  = m_last_q;
    assign grant_valid         = (state_q == BUSY);
    assign grant_id            = grant_id_q;
    assign pkt_cnt             = pkt_cnt_q;

endmodule

// File: tb/tb_role_trace_arb.sv
// Directed bench for role_trace_arb: per-cycle vector table plus hand sequences for
// backpressure, trace_en gating, reset mid-packet and counter saturation.
module tb_role_trace_arb;

    localparam int NS = 4;
    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             trace_en;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tready;
    logic [NS*DW-1:0] s_tdata;
    logic [NS*KW-1:0] s_tkeep;
    logic [NS-1:0]    s_tlast;
    logic             m_tvalid;
    logic             m_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast;
    logic             grant_valid;
    logic [1:0]       grant_id;
    logic [31:0]      pkt_cnt;

    logic [31:0]      sdat [NS];
    logic [7:0]       skp  [NS];

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] mq[$];

    role_trace_arb #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .trace_en            (trace_en),
        .s_axis_trace_tvalid (s_tvalid),
        .s_axis_trace_tready (s_tready),
        .s_axis_trace_tdata  (s_tdata),
        .s_axis_trace_tkeep  (s_tkeep),
        .s_axis_trace_tlast  (s_tlast),
        .m_axis_trace_tvalid (m_tvalid),
        .m_axis_trace_tready (m_tready),
        .m_axis_trace_tdata  (m_tdata),
        .m_axis_trace_tkeep  (m_tkeep),
        .m_axis_trace_tlast  (m_tlast),
        .grant_valid         (grant_valid),
        .grant_id            (grant_id),
        .pkt_cnt             (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    always_comb begin
        s_tdata = '0;
        s_tkeep = '0;
        for (int i = 0; i < NS; i++) begin
            s_tdata[i*DW +: DW] = {480'b0, sdat[i]};
            s_tkeep[i*KW +: KW] = {56'b0, skp[i]};
        end
    end

    // Output monitor: records every handshake as {tlast, tdata[31:0]}.
    initial begin
        forever begin
            @(negedge aclk);
            #2;
            if (aresetn && m_tvalid && m_tready) mq.push_back({m_tlast, m_tdata[31:0]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  vld;
        logic        lst;
        logic [31:0] b;
        logic [7:0]  kp;
        logic        mrdy;
        logic [3:0]  x_srdy;
        logic        x_mv;
        logic [31:0] x_md;
        logic        x_ml;
        logic [7:0]  x_mk;
        logic        x_gv;
        logic [1:0]  x_gid;
        logic [31:0] x_pkt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(int rst, int en, int vld, int lst, int b, int kp, int mrdy,
                                int srdy, int mv, int md, int ml, int mkp, int gv, int gid, int pkt);
        vec_t v;
        v.rst = 1'(rst);   v.en = 1'(en);      v.vld = 4'(vld);   v.lst = 1'(lst);
        v.b = 32'(b);      v.kp = 8'(kp);      v.mrdy = 1'(mrdy);
        v.x_srdy = 4'(srdy); v.x_mv = 1'(mv);  v.x_md = 32'(md);  v.x_ml = 1'(ml);
        v.x_mk = 8'(mkp);  v.x_gv = 1'(gv);    v.x_gid = 2'(gid); v.x_pkt = 32'(pkt);
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn  = 1'b0;
        trace_en = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            sdat[i] = '0;
            skp[i]  = 8'hFF;
        end
        @(negedge aclk);
        aresetn = 1'b1;
        mq.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Sends nb beats from src (data = src<<16 | beat#). When bp is set m_tready toggles 1,0,...
    // drop_at>0 clears trace_en and raises a 1-beat packet on src 3 after that many beats.
    task automatic send_pkt(input int src, input int nb, input int drop_at, input bit bp);
        int beat;
        int guard;
        beat  = 0;
        guard = 0;
        m_tready = 1'b1;
        while (beat < nb && guard < 100) begin
            @(negedge aclk);
            if (bp) m_tready = (guard % 2 == 0);
            s_tvalid[src] = 1'b1;
            sdat[src]     = 32'((src << 16) | (beat + 1));
            skp[src]      = 8'hFF;
            s_tlast[src]  = (beat == nb - 1);
            #1;
            if (m_tvalid && !m_tready) check("bp_srdy_zero", 64'(s_tready), 64'(0));
            if (s_tready[src]) begin
                beat++;
                if (beat == drop_at) begin
                    trace_en    = 1'b0;
                    s_tvalid[3] = 1'b1;
                    sdat[3]     = 32'h30001;
                    s_tlast[3]  = 1'b1;
                    skp[3]      = 8'hFF;
                end
            end
            guard++;
        end
        if (beat < nb) check("send_timeout", 64'(beat), 64'(nb));
        @(negedge aclk);
        s_tvalid[src] = 1'b0;
        s_tlast[src]  = 1'b0;
        m_tready      = 1'b1;
    endtask

    initial begin
        int beat;
        int guard;
        logic [32:0] exp_b;
        trace_en = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            sdat[i] = '0;
            skp[i]  = 8'hFF;
        end

        // rst en vld lst b kp mrdy | srdy mv md ml mk gv gid pkt
        vt.push_back(mk(1,1,'b0100,0,'hA,'hFF,1, 'b0000,0,0,0,0,0,0,0));
        vt.push_back(mk(0,1,'b0100,0,'hA,'hFF,1, 'b0100,0,0,0,0,1,2,0));
        vt.push_back(mk(0,1,'b0100,0,'hB,'h00,1, 'b0100,1,'h2000A,0,'hFF,1,2,0));
        vt.push_back(mk(0,1,'b0100,1,'hC,'hFF,1, 'b0100,1,'h2000B,0,'h00,1,2,0));
        vt.push_back(mk(0,1,'b0000,0,0,'hFF,1,   'b0000,1,'h2000C,1,'hFF,0,2,0));
        vt.push_back(mk(0,1,'b0000,0,0,'hFF,1,   'b0000,0,'h2000C,1,'hFF,0,2,1));
        vt.push_back(mk(0,0,'b0001,0,'hD,'hFF,1, 'b0000,0,'h2000C,1,'hFF,0,2,1));
        vt.push_back(mk(0,0,'b0001,0,'hD,'hFF,1, 'b0000,0,'h2000C,1,'hFF,0,2,1));
        vt.push_back(mk(0,1,'b0001,1,'hD,'hFF,1, 'b0000,0,'h2000C,1,'hFF,0,2,1));
        vt.push_back(mk(0,1,'b0001,1,'hD,'hFF,1, 'b0001,0,'h2000C,1,'hFF,1,0,1));
        vt.push_back(mk(0,1,'b0000,0,0,'hFF,1,   'b0000,1,'h0000D,1,'hFF,0,0,1));
        vt.push_back(mk(0,1,'b0000,0,0,'hFF,1,   'b0000,0,'h0000D,1,'hFF,0,0,2));
        // round robin, all sources valid, 2-beat packets
        vt.push_back(mk(1,1,'b1111,0,1,'hFF,1, 'b0000,0,0,0,0,0,0,0));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b0001,0,0,0,0,1,0,0));
        vt.push_back(mk(0,1,'b1111,1,2,'hFF,1, 'b0001,1,'h00001,0,'hFF,1,0,0));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b0000,1,'h00002,1,'hFF,0,0,0));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b0010,0,'h00002,1,'hFF,1,1,1));
        vt.push_back(mk(0,1,'b1111,1,2,'hFF,1, 'b0010,1,'h10001,0,'hFF,1,1,1));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b0000,1,'h10002,1,'hFF,0,1,1));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b0100,0,'h10002,1,'hFF,1,2,2));
        vt.push_back(mk(0,1,'b1111,1,2,'hFF,1, 'b0100,1,'h20001,0,'hFF,1,2,2));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b0000,1,'h20002,1,'hFF,0,2,2));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b1000,0,'h20002,1,'hFF,1,3,3));
        vt.push_back(mk(0,1,'b1111,1,2,'hFF,1, 'b1000,1,'h30001,0,'hFF,1,3,3));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b0000,1,'h30002,1,'hFF,0,3,3));
        vt.push_back(mk(0,1,'b1111,0,1,'hFF,1, 'b0001,0,'h30002,1,'hFF,1,0,4));
        vt.push_back(mk(0,1,'b1111,1,2,'hFF,1, 'b0001,1,'h00001,0,'hFF,1,0,4));
        vt.push_back(mk(0,1,'b0000,0,0,'hFF,1, 'b0000,1,'h00002,1,'hFF,0,0,4));
        vt.push_back(mk(0,1,'b0000,0,0,'hFF,1, 'b0000,0,'h00002,1,'hFF,0,0,5));

        for (int k = 0; k < vt.size(); k++) begin
            if (vt[k].rst) do_reset();
            @(negedge aclk);
            trace_en = vt[k].en;
            s_tvalid = vt[k].vld;
            m_tready = vt[k].mrdy;
            for (int i = 0; i < NS; i++) begin
                sdat[i]    = (32'(i) << 16) | vt[k].b;
                skp[i]     = vt[k].kp;
                s_tlast[i] = vt[k].lst;
            end
            #1;
            check($sformatf("row%0d s_tready", k), 64'(s_tready), 64'(vt[k].x_srdy));
            check($sformatf("row%0d m_tvalid", k), 64'(m_tvalid), 64'(vt[k].x_mv));
            check($sformatf("row%0d m_tdata", k), 64'(m_tdata[31:0]), 64'(vt[k].x_md));
            check($sformatf("row%0d m_tlast", k), 64'(m_tlast), 64'(vt[k].x_ml));
            check($sformatf("row%0d m_tkeep", k), m_tkeep, {56'b0, vt[k].x_mk});
            check($sformatf("row%0d grant_valid", k), 64'(grant_valid), 64'(vt[k].x_gv));
            check($sformatf("row%0d grant_id", k), 64'(grant_id), 64'(vt[k].x_gid));
            check($sformatf("row%0d pkt_cnt", k), 64'(pkt_cnt), 64'(vt[k].x_pkt));
        end

        // Backpressure: 4-beat packet from src 0 with m_tready toggling.
        do_reset();
        trace_en = 1'b1;
        send_pkt(0, 4, 0, 1'b1);
        idle_cycles(4);
        check("bp_count", 64'(mq.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            exp_b = {(k == 3), 32'(k + 1)};
            if (k < mq.size()) check($sformatf("bp_beat%0d", k), 64'(mq[k]), 64'(exp_b));
        end
        check("bp_pkt_cnt", 64'(pkt_cnt), 64'(1));

        // trace_en dropped after beat 1 of a src 1 packet; src 3 waits until re-enabled.
        do_reset();
        trace_en = 1'b1;
        send_pkt(1, 4, 1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("en_off_gv%0d", k), 64'(grant_valid), 64'(0));
            check($sformatf("en_off_srdy%0d", k), 64'(s_tready), 64'(0));
            @(negedge aclk);
        end
        check("en_count", 64'(mq.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            exp_b = {(k == 3), 32'(32'h10000 + k + 1)};
            if (k < mq.size()) check($sformatf("en_beat%0d", k), 64'(mq[k]), 64'(exp_b));
        end
        trace_en = 1'b1;
        @(negedge aclk);
        #1;
        check("en_regrant_gv", 64'(grant_valid), 64'(1));
        check("en_regrant_id", 64'(grant_id), 64'(3));
        check("en_regrant_srdy", 64'(s_tready), 64'(4'b1000));
        @(negedge aclk);
        s_tvalid[3] = 1'b0;
        s_tlast[3]  = 1'b0;
        idle_cycles(3);
        check("en_pkt_cnt", 64'(pkt_cnt), 64'(2));
        check("en_src3_beat", 64'(mq.size() > 4 ? mq[4] : 33'h0), 64'({1'b1, 32'h30001}));

        // Reset in the middle of a src 2 packet after rr_ptr has moved to 1.
        do_reset();
        trace_en = 1'b1;
        send_pkt(0, 1, 0, 1'b0);
        idle_cycles(3);
        beat  = 0;
        guard = 0;
        while (beat < 2 && guard < 20) begin
            @(negedge aclk);
            s_tvalid[2] = 1'b1;
            sdat[2]     = 32'(32'h20000 + beat + 1);
            s_tlast[2]  = 1'b0;
            #1;
            if (s_tready[2]) beat++;
            guard++;
        end
        if (beat < 2) check("rst_timeout", 64'(beat), 64'(2));
        @(negedge aclk);
        #1;
        check("rst_pre_mv", 64'(m_tvalid), 64'(1));
        check("rst_pre_md", 64'(m_tdata[31:0]), 64'(32'h20002));
        #2;
        aresetn = 1'b0;
        #1;
        check("rst_srdy", 64'(s_tready), 64'(0));
        check("rst_mv", 64'(m_tvalid), 64'(0));
        check("rst_md", 64'(m_tdata[31:0]), 64'(0));
        check("rst_mk", m_tkeep, 64'(0));
        check("rst_ml", 64'(m_tlast), 64'(0));
        check("rst_gv", 64'(grant_valid), 64'(0));
        check("rst_gid", 64'(grant_id), 64'(0));
        check("rst_pkt", 64'(pkt_cnt), 64'(0));
        s_tvalid = 4'b0101;
        s_tlast  = 4'b0101;
        sdat[0]  = 32'h00001;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        check("rst_regrant_gv", 64'(grant_valid), 64'(1));
        check("rst_regrant_id", 64'(grant_id), 64'(0));
        @(negedge aclk);
        s_tvalid = '0;
        s_tlast  = '0;
        idle_cycles(3);
        check("rst_post_pkt", 64'(pkt_cnt), 64'(1));

        // Saturation of the packet counter.
        do_reset();
        trace_en = 1'b1;
        @(negedge aclk);
        force dut.pkt_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.pkt_cnt_q;
        #1;
        check("sat_preload", 64'(pkt_cnt), 64'(32'hFFFF_FFFE));
        for (int p = 0; p < 3; p++) begin
            send_pkt(p, 1, 0, 1'b0);
            idle_cycles(2);
            check($sformatf("sat_pkt%0d", p), 64'(pkt_cnt), 64'(32'hFFFF_FFFF));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/role_trace_arb.md
# role_trace_arb

Packet-level round-robin arbiter that merges up to NUM_SRC accelerator trace sources onto the single 512-bit role trace stream, m_axis_trace. It sits inside the role, between the per-engine trace generators and the role's trace output port. Each grant is held until the granted source's tlast beat is accepted, so packets are never interleaved. The output is registered.

## Interface
Parameters:
- NUM_SRC, 4: number of trace sources; legal range 2..16. SW = max(1, $clog2(NUM_SRC)).
- DATA_WIDTH, 512: tdata width; tkeep is DATA_WIDTH/8.

Ports:
- aclk  in  1  single clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- trace_en  in  1  level; 1 allows new grants.
- s_axis_trace_tvalid  in  NUM_SRC  per-source valid.
- s_axis_trace_tready  out  NUM_SRC  per-source ready; one-hot or zero.
- s_axis_trace_tdata  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_trace_tkeep  in  NUM_SRC*DATA_WIDTH/8  packed the same way as tdata.
- s_axis_trace_tlast  in  NUM_SRC  per-source end of packet.
- m_axis_trace_tvalid  out  1  merged stream valid.
- m_axis_trace_tready  in  1  merged stream ready.
- m_axis_trace_tdata  out  DATA_WIDTH  merged data.
- m_axis_trace_tkeep  out  DATA_WIDTH/8  merged keep.
- m_axis_trace_tlast  out  1  merged end of packet.
- grant_valid  out  1  arbiter is in the BUSY state.
- grant_id  out  SW  index of the granted source.
- pkt_cnt  out  32  count of packets fully forwarded; saturates at 0xFFFF_FFFF.

## Operation
- State machine with two states, IDLE and BUSY.
- IDLE:
  - s_axis_trace_tready is all zero.
  - If trace_en=1 and any s_tvalid is 1, pick the winner: the first valid index at or after rr_ptr, scanning upward and wrapping from NUM_SRC-1 to 0.
  - On that edge: grant_id <= winner, grant_valid <= 1, move to BUSY.
- BUSY:
  - s_tready[grant_id] = (!m_tvalid | m_tready); all other tready bits are 0.
  - An accepted source beat (s_tvalid & s_tready on grant_id) loads the output register with tdata, tkeep and tlast unchanged. tkeep=0 beats are forwarded as-is.
  - When the accepted beat has tlast=1: next state is IDLE, grant_valid <= 0, rr_ptr <= (grant_id+1) mod NUM_SRC.
- Output register:
  - m_tvalid is set on an accepted beat.
  - m_tvalid is cleared when m_tready=1 and no new beat is accepted in the same cycle.
  - m_tdata, m_tkeep and m_tlast change only when a beat is loaded.
- pkt_cnt increments by 1 on each output handshake with m_tlast=1, and holds at 0xFFFF_FFFF.
- trace_en:
  - trace_en=0 blocks new grants only.
  - A packet already granted always completes, whatever trace_en does.
- Other sources' tvalid may rise or fall at any time without affecting the current grant.
- A source that drops tvalid mid-packet stalls the arbiter in BUSY. No timeout.

## Timing
- Reset values (async assert, sync deassert is external): state IDLE, rr_ptr 0, grant_valid 0, grant_id 0, all s_tready 0, m_tvalid 0, m_tdata 0, m_tkeep 0, m_tlast 0, pkt_cnt 0.
- Reset mid-packet truncates the packet; no recovery beat is emitted.
- Grant latency: s_tvalid rises in cycle 0 while IDLE with the output empty.
  - Edge 1: grant taken.
  - Cycle 1: s_tready=1 and the first beat is accepted.
  - Cycle 2: m_tvalid=1.
- Throughput: 1 beat/cycle while m_tready=1.
- Packet gap: exactly 1 idle arbitration cycle on the sink side between back-to-back packets. The output register still drains during that cycle.
- Simultaneous events:
  - tlast accepted while other sources are valid: go to IDLE; the new grant comes on the next edge.
  - Output drained and a new beat loaded in the same cycle: m_tvalid stays 1.
- No combinational path from any s_tvalid to s_tready. The only combinational path is m_tready to s_tready.

## Test plan
- Single source: src 2 sends a 3-beat packet (data 0xA,0xB,0xC, last on beat 3), m_tready=1.
  - Required: m_tvalid high cycles 2–4 with 0xA,0xB,0xC and m_tlast on 0xC.
  - grant_id=2; pkt_cnt=1.
- Round robin: all 4 sources continuously valid, 2-beat packets.
  - Required: output order src 0,1,2,3,0; exactly one idle cycle between packets.
  - Beats are never interleaved.
- Backpressure: m_tready toggles 1,0,1,0 during a 4-beat packet.
  - Required: no beat lost or duplicated.
  - s_tready is 0 whenever the output is full and m_tready=0.
- trace_en: drop trace_en after beat 1 of a 4-beat packet from src 1.
  - Required: all 4 beats forwarded, then grant_valid=0.
  - No new grant while trace_en=0, even with src 3 valid.
- Reset mid-packet: assert aresetn=0 at beat 2.
  - Required: all outputs immediately at reset values.
  - After release, the first grant goes to the lowest valid index (rr_ptr=0).
- Saturation: force pkt_cnt to 0xFFFF_FFFE, then forward 3 packets.
  - Required: pkt_cnt=0xFFFF_FFFF and held.
